trace_commit_fifo: RTL and testbench

Sits directly downstream of the picorv32_axi trace port (trace_valid/trace_data) in picorv32_wrapper and buffers every trace word for the Spike co-simulation checker, which drains it at its own pace through a valid/ready pop interface.
The core's trace port has no backpressure, so the block absorbs bursts and classifies entries by kind.
It also reports loss (overflow, drop count) so the checker can tell a real mismatch from a dropped record.

---
 rtl/trace_pkg.sv | 11 +
 rtl/trace_commit_fifo_if.sv | 15 +
 rtl/sync_fifo_fwft.sv | 49 ++++
 rtl/trace_commit_fifo.sv | 63 ++++++
 tb/tb_trace_commit_fifo.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - trace word layout constants shared with the cosim checker
package trace_pkg;
    localparam int TRACE_W     = 36;
    localparam int KIND_HI     = 35;
    localparam int KIND_LO     = 32;
    localparam int KIND_BRANCH = 0;
    localparam int KIND_ADDR   = 1;
    localparam int KIND_IRQ    = 3;

    typedef logic [KIND_HI-KIND_LO:0] trace_kind_t;
endpackage

// File: rtl/trace_commit_fifo_if.sv
// rtl/trace_commit_fifo_if.sv - trace push and valid/ready pop signals
interface trace_commit_fifo_if;
    import trace_pkg::*;

    logic               trace_valid;
    logic [TRACE_W-1:0] trace_data;
    logic               out_valid;
    logic               out_ready;
    logic [TRACE_W-1:0] out_data;

    modport master (output trace_valid, output trace_data, output out_ready,
                    input  out_valid,   input  out_data);
    modport slave  (input  trace_valid, input  trace_data, input  out_ready,
                    output out_valid,   output out_data);
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - generic first-word-fall-through circular buffer
module sync_fifo_fwft #(
    parameter int W     = 36,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          push_ok
);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop_ok  = pop && !empty && !flush;
    // A full buffer still takes a word when the head leaves in the same cycle.
    assign push_ok = push && !flush && (!full || pop_ok);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/trace_commit_fifo.sv
// rtl/trace_commit_fifo.sv - trace buffer with loss accounting and per-kind counters
module trace_commit_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    trace_commit_fifo_if.slave       bus,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [CNT_W-1:0]         branch_count,
    output logic [CNT_W-1:0]         addr_count,
    output logic [CNT_W-1:0]         irq_count
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic push;
    logic push_ok;
    logic drop;
    logic empty;

    assign push = bus.trace_valid && !flush;
    assign drop = push && !push_ok;
    assign bus.out_valid = !empty;

    sync_fifo_fwft #(.W(TRACE_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (bus.out_ready),
        .flush   (flush),
        .wdata   (bus.trace_data),
        .rdata   (bus.out_data),
        .empty   (empty),
        .level   (level),
        .push_ok (push_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow     <= 1'b0;
            drop_count   <= '0;
            branch_count <= '0;
            addr_count   <= '0;
            irq_count    <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
            // Only words that actually land in the buffer are classified.
            if (push_ok) begin
                if (bus.trace_data[KIND_LO+KIND_BRANCH]) branch_count <= branch_count + CNT_ONE;
                if (bus.trace_data[KIND_LO+KIND_ADDR])   addr_count   <= addr_count + CNT_ONE;
                if (bus.trace_data[KIND_LO+KIND_IRQ])    irq_count    <= irq_count + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_trace_commit_fifo.sv
// tb/tb_trace_commit_fifo.sv - directed self-checking bench for trace_commit_fifo
module tb_trace_commit_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] branch_count;
    logic [31:0] addr_count;
    logic [31:0] irq_count;

    int total = 0;
    int bad   = 0;

    trace_commit_fifo_if bus ();

    trace_commit_fifo #(.DEPTH(16), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .flush        (flush),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .branch_count (branch_count),
        .addr_count   (addr_count),
        .irq_count    (irq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.trace_valid = 1'b0;
        bus.trace_data  = '0;
        bus.out_ready   = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [35:0] d);
        bus.trace_valid = 1'b1;
        bus.trace_data  = d;
        tick();
        bus.trace_valid = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_counts", {branch_count, addr_count}, 0);
        chk("rst_irq", irq_count, 0);

        // 1: three kinds, first-word latency and head value
        do_reset();
        push_word(36'h1_0000_0100);
        chk("t1_latency_valid", bus.out_valid, 1);
        push_word(36'h2_0000_2000);
        push_word(36'h8_0000_0010);
        chk("t1_level", level, 3);
        chk("t1_head", bus.out_data, 36'h1_0000_0100);
        chk("t1_branch", branch_count, 1);
        chk("t1_addr", addr_count, 1);
        chk("t1_irq", irq_count, 1);

        // 2: overfill by four, then drain in order
        do_reset();
        for (int i = 0; i < 20; i++) push_word(36'(i));
        chk("t2_level", level, 16);
        chk("t2_ovf", overflow, 1);
        chk("t2_drop", drop_count, 4);
        chk("t2_branch", branch_count, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_pop_data", bus.out_data, 64'(i));
            tick();
        end
        chk("t2_empty", bus.out_valid, 0);
        chk("t2_level0", level, 0);
        bus.out_ready = 1'b0;

        // 3: full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) push_word(36'(i));
        chk("t3_full_ovf", overflow, 0);
        bus.trace_valid = 1'b1;
        bus.trace_data  = 36'h0_DEAD_BEEF;
        bus.out_ready   = 1'b1;
        chk("t3_head0", bus.out_data, 0);
        tick();
        bus.trace_valid = 1'b0;
        bus.out_ready   = 1'b0;
        chk("t3_level", level, 16);
        chk("t3_drop", drop_count, 0);
        chk("t3_ovf", overflow, 0);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("t3_drain", bus.out_data, 64'(i));
            tick();
        end
        chk("t3_last", bus.out_data, 36'h0_DEAD_BEEF);
        tick();
        chk("t3_empty", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // 4: streaming push and pop, pointers wrap
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.trace_valid = 1'b1;
            bus.trace_data  = 36'(100 + i);
            if (i == 0) begin
                chk("t4_first_level", level, 0);
                chk("t4_first_valid", bus.out_valid, 0);
            end else begin
                chk("t4_stream_data", bus.out_data, 64'(99 + i));
                chk("t4_stream_level", level, 1);
            end
            tick();
        end
        bus.trace_valid = 1'b0;
        chk("t4_tail", bus.out_data, 64'(199));
        tick();
        chk("t4_drained", level, 0);
        bus.out_ready = 1'b0;

        // 5: flush with a concurrent push
        do_reset();
        for (int i = 0; i < 5; i++) push_word(36'h1_0000_0000 | 36'(i));
        chk("t5_level5", level, 5);
        flush           = 1'b1;
        bus.trace_valid = 1'b1;
        bus.trace_data  = 36'h1_0000_00FF;
        tick();
        flush           = 1'b0;
        bus.trace_valid = 1'b0;
        chk("t5_level", level, 0);
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_branch", branch_count, 5);
        chk("t5_drop", drop_count, 0);
        push_word(36'h0_0000_0077);
        chk("t5_next_head", bus.out_data, 36'h0_0000_0077);
        chk("t5_next_level", level, 1);

        // 6: drop counter saturation, then reset mid-stream
        do_reset();
        for (int i = 0; i < 16; i++) push_word(36'hF_0000_0000 | 36'(i));
        bus.trace_valid = 1'b1;
        bus.trace_data  = 36'hF_1234_5678;
        for (int i = 0; i < 65540; i++) tick();
        chk("t6_drop_sat", drop_count, 16'hFFFF);
        chk("t6_ovf", overflow, 1);
        chk("t6_level", level, 16);
        chk("t6_branch", branch_count, 16);
        chk("t6_irq", irq_count, 16);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.trace_valid = 1'b0;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_drop", drop_count, 0);
        chk("t6_rst_branch", branch_count, 0);
        chk("t6_rst_addr", addr_count, 0);
        chk("t6_rst_irq", irq_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
